// File: rtl/countdown_ctrl.sv
// countdown_ctrl -- sequencer that drives countdown_top's reset/enable pins
// and consumes its done level.
//
// A start command (accepted only while idle) latches a repeat count and runs
// periods of CLEAR (countdown held in reset for CLR_CYCLES) then RUN
// (countdown enabled). The first GUARD cycles of RUN ignore i_cd_done so that
// a stale done still travelling through countdown_top's registers cannot be
// mistaken for a completion. Each completion emits o_tick and bumps o_count;
// the block re-arms until the repeat count is reached (0 = forever) or an
// abort arrives.
//
// Parameters:
//   RW          width of repeat count / completion counter
//   CLR_CYCLES  cycles o_cd_reset is held in CLEAR per period (>= 1)
//   GUARD       RUN cycles during which i_cd_done is ignored (>= 1)
//
// Ports:
//   clock        system clock
//   i_reset      synchronous active-high reset
//   i_start      start request, accepted only when o_busy = 0
//   i_repeat     periods to run (0 = until abort), sampled on accepted start
//   i_abort      return to IDLE on the next edge; blocks a start when idle
//   i_pause      hold countdown enable low in RUN (optional feature)
//   i_cd_done    done level from countdown_top
//   o_cd_reset   to countdown_top reset
//   o_cd_enable  to countdown_top enable
//   o_busy       high in CLEAR and RUN
//   o_tick       one-cycle pulse per completed period
//   o_last       one-cycle pulse with the final tick
//   o_count      completed periods since the last accepted start
//
// Optional feature: define COUNTDOWN_CTRL_PAUSE_EN to make i_pause drop the
// countdown enable (1-cycle registered latency) and freeze the guard counter
// while in RUN. Without it i_pause is ignored.

module countdown_ctrl #(
    parameter int unsigned RW         = 16,
    parameter int unsigned CLR_CYCLES = 3,
    parameter int unsigned GUARD      = 3
) (
    input  logic          clock,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [RW-1:0] i_repeat,
    input  logic          i_abort,
    input  logic          i_pause,
    input  logic          i_cd_done,
    output logic          o_cd_reset,
    output logic          o_cd_enable,
    output logic          o_busy,
    output logic          o_tick,
    output logic          o_last,
    output logic [RW-1:0] o_count
);

    // One counter serves both the CLEAR hold and the RUN guard window.
    localparam int unsigned CMAX = (CLR_CYCLES > GUARD) ? CLR_CYCLES : GUARD;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [RW-1:0] rep_q;
    logic [RW-1:0] count_next;
    logic          paused;

`ifdef COUNTDOWN_CTRL_PAUSE_EN
    assign paused = i_pause;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
    assign paused       = 1'b0;
`endif

    assign count_next = o_count + RW'(1);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= IDLE;
            cyc         <= '0;
            rep_q       <= '0;
            o_cd_reset  <= 1'b1;
            o_cd_enable <= 1'b0;
            o_busy      <= 1'b0;
            o_tick      <= 1'b0;
            o_last      <= 1'b0;
            o_count     <= '0;
        end else begin
            o_tick <= 1'b0;
            o_last <= 1'b0;

            case (state)
                IDLE: begin
                    o_cd_reset  <= 1'b1;
                    o_cd_enable <= 1'b0;
                    if (i_start && !i_abort) begin
                        rep_q   <= i_repeat;
                        o_count <= '0;
                        cyc     <= '0;
                        o_busy  <= 1'b1;
                        state   <= CLEAR;
                    end
                end

                CLEAR: begin
                    if (i_abort) begin
                        o_busy <= 1'b0;
                        cyc    <= '0;
                        state  <= IDLE;
                    end else if (cyc == CLR_LAST) begin
                        // Pause is deliberately not honoured on entry to RUN.
                        cyc         <= '0;
                        o_cd_reset  <= 1'b0;
                        o_cd_enable <= 1'b1;
                        state       <= RUN;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end

                RUN: begin
                    if (i_abort) begin
                        o_cd_reset  <= 1'b1;
                        o_cd_enable <= 1'b0;
                        o_busy      <= 1'b0;
                        cyc         <= '0;
                        state       <= IDLE;
                    end else if (cyc == GUARD_END && i_cd_done) begin
                        // Completion: drop enable and re-clear in the same update.
                        o_tick      <= 1'b1;
                        o_count     <= count_next;
                        o_cd_reset  <= 1'b1;
                        o_cd_enable <= 1'b0;
                        cyc         <= '0;
                        if (rep_q != '0 && count_next == rep_q) begin
                            o_last <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= CLEAR;
                        end
                    end else begin
                        // Guard counter saturates at GUARD and freezes while paused.
                        if (cyc != GUARD_END && !paused) begin
                            cyc <= cyc + CW'(1);
                        end
                        o_cd_enable <= !paused;
                    end
                end

                default: begin
                    o_cd_reset  <= 1'b1;
                    o_cd_enable <= 1'b0;
                    o_busy      <= 1'b0;
                    cyc         <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencer directly upstream of countdown_top; it drives that block's reset/enable inputs and consumes its done output.
- Accepts a start command carrying a repeat count.
- Clears and arms the countdown, and waits for done after masking the countdown's register-pipeline latency.
- Emits a tick per completed period; re-arms until the repeat count is reached or an abort arrives.

Parameters:
RW, 16, width of repeat count and completion counter
CLR_CYCLES, 3, cycles o_cd_reset is held in CLEAR before each period (min 1)
GUARD, 3, cycles after entering RUN during which i_cd_done is ignored (covers countdown in/out registers; min 1)

Ports:
clock  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request; accepted only when o_busy=0
i_repeat  input  RW  periods to run; 0 = run until abort; sampled on accepted start
i_abort  input  1  stop immediately and return to IDLE
i_pause  input  1  hold countdown enable low while asserted (see Optional Feature)
i_cd_done  input  1  done level from countdown_top
o_cd_reset  output  1  to countdown_top i_reset
o_cd_enable  output  1  to countdown_top i_enable
o_busy  output  1  high in CLEAR and RUN
o_tick  output  1  one-cycle pulse per completed period
o_last  output  1  one-cycle pulse coincident with the final tick
o_count  output  RW  completed periods since last accepted start

Behaviour:
- Interface: one clock, clock; reset i_reset is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, o_cd_reset=1, o_cd_enable=0, o_busy=0, o_tick=0, o_last=0, o_count=0, internal cycle counter=0.
- IDLE:
  - o_cd_reset=1, o_cd_enable=0.
  - i_start=1 and i_abort=0: latch i_repeat, clear o_count, go to CLEAR. o_busy=1 from the next cycle.
  - i_start together with i_abort: start ignored.
- CLEAR:
  - o_cd_reset=1, o_cd_enable=0.
  - Stay exactly CLR_CYCLES cycles, then go to RUN.
- RUN:
  - o_cd_reset=0, o_cd_enable=1.
  - Guard counter counts the first GUARD cycles; i_cd_done is ignored during them.
  - After the guard, i_cd_done=1 marks a completion:
    - o_tick=1 for one cycle.
    - o_count increments, wrapping mod 2^RW.
    - o_cd_enable=0 in the same registered update.
  - If the latched repeat is nonzero and the new count equals it: o_last=1 with the tick, go to IDLE.
  - Otherwise go to CLEAR for the next period.
- Abort (CLEAR or RUN):
  - Next cycle: state=IDLE, o_cd_enable=0, o_cd_reset=1, no tick, o_count retains its value.
  - Abort and completion in the same cycle: abort wins, no tick.
- i_start while busy: ignored; no queuing.
- Repeat=1: exactly one period, then o_last.
- Repeat=0: o_last is never asserted; o_count wraps 0xFFFF->0 with RW=16.
- i_reset mid-operation: all state returns to reset values next cycle; o_cd_reset asserted immediately at that edge.
- Latency, accepted start -> first o_cd_enable=1: 1 + CLR_CYCLES cycles.
- Latency, valid i_cd_done -> o_tick: 1 cycle.

Optional Feature:
- Macro: COUNTDOWN_CTRL_PAUSE_EN.
- Defined:
  - In RUN, i_pause=1 forces o_cd_enable=0 (registered, 1-cycle latency). The countdown holds its state.
  - Guard counter freezes while paused.
  - Completion detection still active (a done already in flight is honoured).
  - Pause has no effect in IDLE or CLEAR.
- Undefined: i_pause is ignored; no logic is generated for it.

Test Plan:
- Reset with i_reset=1 for 2 cycles -> o_cd_reset=1, o_cd_enable=0, o_busy=0, o_count=0.
- Start with i_repeat=3, stub i_cd_done pulsing 10 cycles after each enable rise -> o_cd_enable rises 4 cycles after start; 3 ticks; o_count=1,2,3; o_last with 3rd tick; then IDLE with o_cd_reset=1.
- Start with i_repeat=2, i_cd_done held 1 (stale) during CLEAR and the first 3 RUN cycles, then low -> no tick during the guard window; o_count=0.
- Abort 5 cycles into RUN of period 2 with i_repeat=0 -> next cycle o_busy=0, o_cd_enable=0, o_count=1; a simultaneous i_start on the abort cycle is ignored.
- i_repeat=0 with o_count preloaded to 0xFFFE via 2 forced wraps (or a short stub) -> count sequence 0xFFFF, 0x0000; o_last never asserted.
- With COUNTDOWN_CTRL_PAUSE_EN: i_pause=1 for 6 cycles in RUN -> o_cd_enable=0 for those 6 cycles (shifted by 1); tick timing extended by 6 cycles. Without the macro: o_cd_enable unchanged.
